wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage of the 16-bit pipeline, directly downstream of MEM.
//  - Latches MEM outputs (wb, we, instr) in a MEM/WB register.
//  - Commits the latched value into a 16x16 register file one cycle later.
//  - Provides two combinational read ports for decode.
//  - CALL/RET results (the updated SP) are steered to the stack-pointer register.
// PARAMETERS
//  SP_IDX   15       register index used as stack pointer by CALL/RET
//  SP_INIT  16'h00FF SP reset value; all other registers reset to 0
//  R0_ZERO  1        1: R0 reads 0 and ignores writes; 0: R0 is a normal register
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   synchronous reset, active low
//  mem_valid  in   1   MEM holds a real instruction this cycle
//  mem_wb     in   16  MEM result to write back (MEM port wb)
//  mem_we     in   1   MEM register-write request (MEM port we)
//  mem_instr  in   16  instruction in MEM; [15:12] opcode, [11:8] rd
//  stall      in   1   hold MEM/WB latch, suppress commit
//  flush      in   1   invalidate MEM/WB latch
//  rs_addr    in   4   read port A address
//  rt_addr    in   4   read port B address
//  rs_data    out  16  read port A data (combinational)
//  rt_data    out  16  read port B data (combinational)
//  wb_valid   out  1   latch holds a pending write (valid_q & we_q)
//  wb_dst     out  4   latched destination index
//  wb_data    out  16  latched write data, for the hazard/forward unit
//  sp_out     out  16  current SP register contents
// BEHAVIOUR
//  - Destination decode: opcode `CALL or `RET -> SP_IDX; otherwise mem_instr[11:8].
//  - Edge priority: rst_n=0 > flush > stall > normal.
//  - Reset (rst_n=0 at edge):
//    - valid_q=0, we_q=0, dst_q=0, data_q=0.
//    - RF cleared; SP loaded with SP_INIT.
//    - Any pending write is discarded.
//  - Normal edge:
//    - Commit: if valid_q&we_q, RF[dst_q]<=data_q.
//    - Latch: valid_q<=mem_valid, we_q<=mem_we&mem_valid, dst_q, data_q<=mem_wb.
//  - Latency: MEM value at edge N becomes readable from the RF after edge N+1.
//  - stall=1: latch holds; no commit. The held entry commits exactly once, on the first non-stall edge.
//  - flush=1: valid_q<=0 and we_q<=0. A write already latched still commits on that edge; the incoming MEM instruction is dropped.
//  - R0_ZERO=1: writes to R0 are dropped; reads of R0 return 0. wb_valid still asserts.
//  - Reads with no bypass: RF contents, combinational.
//  - Two reads of the same register return the same value.
//  - we=0 instructions (SW, B) occupy the latch but never commit.
//  - Outputs after reset: rs_data/rt_data=0, except when reading SP_IDX (SP_INIT); wb_valid=0; wb_dst=0; wb_data=0; sp_out=SP_INIT.
// CONFIGURATION
//  WB_FWD_EN defined:
//    - rs_data/rt_data bypass from the latch when wb_valid and addr==wb_dst.
//    - The bypass does not apply to R0 when R0_ZERO=1.
//    - Gives write-then-read in the commit cycle.
//  WB_FWD_EN undefined:
//    - Reads return the old RF value until after the commit edge.
//    - The hazard unit covers that cycle.
// TESTING
//  1. Reset:
//     - Stimulus: rst_n=0 for 2 edges, then read R3 and R15.
//     - Response: 16'h0000 and 16'h00FF; wb_valid=0.
//  2. ADD:
//     - Stimulus: ADD rd=1, mem_wb=16'd10, we=1, valid=1.
//     - Response: wb_dst=1, wb_data=10 after edge 1; rs_data(R1)=10 after edge 2.
//  3. CALL:
//     - Stimulus: CALL, mem_wb=16'd1, we=1.
//     - Response: sp_out=1 after 2 edges; rd field ignored.
//  4. Stall:
//     - Stimulus: LW rd=2, mem_wb=16'h0A0A, then stall=1 for 3 edges.
//     - Response: R2 unchanged during the stall; R2=0A0A one edge after release; single commit.
//  5. Flush, reset and R0:
//     - Flush same edge as ADD rd=4, 16'h1234 -> R4 stays 0.
//     - rst_n=0 with a write pending -> write discarded.
//     - R0 write -> R0 still 0.
//  6. Bypass:
//     - Stimulus: write rd=5=16'hBEEF; read R5 in the commit cycle.
//     - Response: BEEF with WB_FWD_EN defined; old value 0 without it.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB handshake, decode read ports and writeback status of the writeback stage.
interface wb_stage_if;
    logic        mem_valid;
    logic [15:0] mem_wb;
    logic        mem_we;
    logic [15:0] mem_instr;
    logic        stall;
    logic        flush;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic [15:0] sp_out;

    modport master (
        output mem_valid, mem_wb, mem_we, mem_instr, stall, flush, rs_addr, rt_addr,
        input  rs_data, rt_data, wb_valid, wb_dst, wb_data, sp_out
    );
    modport slave (
        input  mem_valid, mem_wb, mem_we, mem_instr, stall, flush, rs_addr, rt_addr,
        output rs_data, rt_data, wb_valid, wb_dst, wb_data, sp_out
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB latch, 16x16 register file commit and two combinational read ports.
// Optional WB_FWD_EN bypasses the pending latched write onto the read ports.
module wb_stage #(
    parameter logic [3:0]  SP_IDX  = 4'd15,
    parameter logic [15:0] SP_INIT = 16'h00FF,
    parameter bit          R0_ZERO = 1'b1,
    parameter logic [3:0]  OP_CALL = 4'hC,
    parameter logic [3:0]  OP_RET  = 4'hD
) (
    input logic       clk,
    input logic       rst_n,
    wb_stage_if.slave bus
);
    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [3:0]  dst_q, dst_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rf_q [16];
    logic [3:0]  op;
    logic        commit;

    assign op = bus.mem_instr[15:12];
    // A latched write still retires on a flush edge; only stall suppresses it.
    assign commit = valid_q & we_q & (bus.flush | ~bus.stall) & ~(R0_ZERO && dst_q == 4'd0);

    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        dst_d   = dst_q;
        data_d  = data_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (!bus.stall) begin
            valid_d = bus.mem_valid;
            we_d    = bus.mem_we & bus.mem_valid;
            dst_d   = (op == OP_CALL || op == OP_RET) ? SP_IDX : bus.mem_instr[11:8];
            data_d  = bus.mem_wb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            dst_q   <= 4'd0;
            data_q  <= 16'd0;
            for (int i = 0; i < 16; i++)
                rf_q[i] <= (4'(i) == SP_IDX) ? SP_INIT : 16'd0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            if (commit)
                rf_q[dst_q] <= data_q;
        end
    end

    function automatic logic [15:0] rd(input logic [3:0] a);
        if (R0_ZERO && a == 4'd0)
            return 16'd0;
`ifdef WB_FWD_EN
        if (valid_q && we_q && a == dst_q)
            return data_q;
`endif
        return rf_q[a];
    endfunction

    assign bus.rs_data  = rd(bus.rs_addr);
    assign bus.rt_data  = rd(bus.rt_addr);
    assign bus.wb_valid = valid_q & we_q;
    assign bus.wb_dst   = dst_q;
    assign bus.wb_data  = data_q;
    assign bus.sp_out   = rf_q[SP_IDX];
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with hand-computed expectations for wb_stage.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wb_stage_if bus ();
    wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] opc, input logic [3:0] rd, input logic [15:0] d);
        bus.mem_valid = v;
        bus.mem_we    = we;
        bus.mem_instr = {opc, rd, 8'h00};
        bus.mem_wb    = d;
    endtask

    task automatic rd2(input logic [3:0] a, input logic [3:0] b);
        bus.rs_addr = a;
        bus.rt_addr = b;
        #1;
    endtask

    initial begin
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        bus.stall = 0;
        bus.flush = 0;
        rd2(4'd3, 4'd15);
        edge_step();
        edge_step();
        rd2(4'd3, 4'd15);
        check("rst_r3", bus.rs_data, 16'h0000);
        check("rst_r15", bus.rt_data, 16'h00FF);
        check("rst_wbv", 16'(bus.wb_valid), 16'h0);
        check("rst_dst", 16'(bus.wb_dst), 16'h0);
        check("rst_wbd", bus.wb_data, 16'h0);
        check("rst_sp", bus.sp_out, 16'h00FF);
        rst_n = 1;

        drive(1, 1, 4'h1, 4'd1, 16'd10);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rd2(4'd1, 4'd1);
        check("add_dst", 16'(bus.wb_dst), 16'd1);
        check("add_wbd", bus.wb_data, 16'd10);
        check("add_wbv", 16'(bus.wb_valid), 16'd1);
        check("add_pre", bus.rs_data, FWD ? 16'd10 : 16'd0);
        edge_step();
        check("add_r1", bus.rs_data, 16'd10);
        check("add_wbv0", 16'(bus.wb_valid), 16'd0);

        drive(1, 1, 4'hC, 4'd3, 16'd1);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        check("call_dst", 16'(bus.wb_dst), 16'd15);
        edge_step();
        rd2(4'd3, 4'd15);
        check("call_sp", bus.sp_out, 16'd1);
        check("call_r3", bus.rs_data, 16'd0);

        drive(1, 1, 4'h2, 4'd2, 16'h0A0A);
        edge_step();
        drive(1, 1, 4'h1, 4'd2, 16'h5555);
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            edge_step();
            rd2(4'd2, 4'd2);
            check("stl_r2", bus.rs_data, FWD ? 16'h0A0A : 16'h0000);
            check("stl_wbd", bus.wb_data, 16'h0A0A);
        end
        bus.stall = 0;
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        edge_step();
        check("stl_rel", bus.rs_data, 16'h0A0A);
        check("stl_wbv0", 16'(bus.wb_valid), 16'd0);

        drive(1, 1, 4'h1, 4'd4, 16'h1234);
        bus.flush = 1;
        edge_step();
        bus.flush = 0;
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        check("fl_wbv", 16'(bus.wb_valid), 16'd0);
        edge_step();
        rd2(4'd4, 4'd4);
        check("fl_r4", bus.rs_data, 16'd0);

        drive(1, 1, 4'h1, 4'd6, 16'h0066);
        edge_step();
        drive(1, 1, 4'h1, 4'd7, 16'h0077);
        bus.flush = 1;
        edge_step();
        bus.flush = 0;
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rd2(4'd6, 4'd7);
        check("fl_r6", bus.rs_data, 16'h0066);
        edge_step();
        check("fl_r7", bus.rt_data, 16'h0000);

        drive(1, 1, 4'h1, 4'd8, 16'h0088);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rst_n = 0;
        edge_step();
        rst_n = 1;
        rd2(4'd8, 4'd1);
        check("rp_wbv", 16'(bus.wb_valid), 16'd0);
        check("rp_sp", bus.sp_out, 16'h00FF);
        check("rp_r1", bus.rt_data, 16'd0);
        edge_step();
        check("rp_r8", bus.rs_data, 16'd0);

        drive(1, 1, 4'h1, 4'd0, 16'hFFFF);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rd2(4'd0, 4'd0);
        check("r0_wbv", 16'(bus.wb_valid), 16'd1);
        check("r0_pre", bus.rs_data, 16'd0);
        edge_step();
        check("r0_post", bus.rt_data, 16'd0);

        drive(1, 1, 4'h1, 4'd5, 16'hBEEF);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rd2(4'd5, 4'd5);
        check("byp_rs", bus.rs_data, FWD ? 16'hBEEF : 16'h0000);
        check("byp_rt", bus.rt_data, FWD ? 16'hBEEF : 16'h0000);
        edge_step();
        check("byp_rs2", bus.rs_data, 16'hBEEF);
        check("byp_rt2", bus.rt_data, 16'hBEEF);

        drive(1, 0, 4'h3, 4'd9, 16'h0099);
        edge_step();
        drive(0, 0, 4'h0, 4'h0, 16'h0);
        rd2(4'd9, 4'd9);
        check("sw_wbv", 16'(bus.wb_valid), 16'd0);
        check("sw_pre", bus.rs_data, 16'd0);
        edge_step();
        check("sw_r9", bus.rs_data, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
